reg_write_scoreboard: RTL and testbench

- Synthesisable, parametrised register-write scoreboard for the processor verification environment.
- Replaces the fixed two-cycle register check with a queue-based comparison. Expected register writes from the processor model are queued in order, then matched against the in-order commits of the RTL processor.
- Tolerates variable pipeline latency and stalls, flags mismatches, timeouts and overflow, and drives end-of-test status.

---
 rtl/scb_pkg.sv | 15 +
 rtl/reg_write_scoreboard_if.sv | 47 ++++
 rtl/scb_fifo.sv | 55 +++++
 rtl/reg_write_scoreboard.sv | 146 ++++++++++++++
 tb/tb_reg_write_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scb_pkg.sv
// Shared types and constants for the register-write scoreboard.
package scb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scb_state_e;

  localparam int REG_ZERO = 0;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int AGE_W    = 8;

endpackage

// File: rtl/reg_write_scoreboard_if.sv
// Stimulus/result bundle of the register-write scoreboard.
// Defining SCB_LAST_ERR_EN adds the last-error capture signals.
interface reg_write_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16,
  parameter int LVL_W  = 4
);
  logic              ExpValid;
  logic [ADDR_W-1:0] ExpAddr;
  logic [DATA_W-1:0] ExpData;
  logic              ActValid;
  logic [ADDR_W-1:0] ActAddr;
  logic [DATA_W-1:0] ActData;
  logic              Finish;
  logic              Match;
  logic              Mismatch;
  logic              Timeout;
  logic              Overflow;
  logic              Error;
  logic              Done;
  logic [CNT_W-1:0]  MatchCnt;
  logic [CNT_W-1:0]  ErrCnt;
  logic [LVL_W-1:0]  Level;
`ifdef SCB_LAST_ERR_EN
  logic [ADDR_W-1:0] ErrAddr;
  logic [DATA_W-1:0] ErrExp;
  logic [DATA_W-1:0] ErrAct;
`endif

  modport master (
    output ExpValid, ExpAddr, ExpData, ActValid, ActAddr, ActData, Finish,
`ifdef SCB_LAST_ERR_EN
    input  ErrAddr, ErrExp, ErrAct,
`endif
    input  Match, Mismatch, Timeout, Overflow, Error, Done, MatchCnt, ErrCnt, Level
  );

  modport slave (
    input  ExpValid, ExpAddr, ExpData, ActValid, ActAddr, ActData, Finish,
`ifdef SCB_LAST_ERR_EN
    output ErrAddr, ErrExp, ErrAct,
`endif
    output Match, Mismatch, Timeout, Overflow, Error, Done, MatchCnt, ErrCnt, Level
  );

endinterface

// File: rtl/scb_fifo.sv
// Synchronous FIFO with read-through head; a pop frees a slot for a same-cycle
// push when full. Pointers wrap modulo DEPTH (power of two).
module scb_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic [W-1:0]     o_head
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_level = r_level;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/reg_write_scoreboard.sv
// In-order register-write scoreboard: queued model writes are matched against
// RTL commits with head ageing. SCB_LAST_ERR_EN adds last-error capture ports.
//
// state | meaning
// IDLE  | after reset, waiting for first activity
// RUN   | comparing commits against queued writes
// DRAIN | finish requested, emptying the queue
// DONE  | test over, inputs ignored until reset
module reg_write_scoreboard
  import scb_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 5,
  parameter  int DEPTH   = 8,
  parameter  int TIMEOUT = 16,
  parameter  int CNT_W   = 16,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input logic                  Clock,
  input logic                  nReset,
  reg_write_scoreboard_if.slave bus
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [AGE_W-1:0]  age;
  } entry_t;

  scb_state_e       r_state, w_state_nxt;
  entry_t           w_head;
  logic [AGE_W-1:0] r_age;
  logic [LVL_W-1:0] w_level;
  logic             w_full, w_empty;
  logic             w_active, w_push_req, w_pop_req;
  logic             w_cmp, w_equal, w_unexp, w_tmo, w_rm, w_ovf, w_err_ev;
  logic             r_match, r_mismatch, r_timeout, r_overflow, r_error;
  logic [CNT_W-1:0] r_match_cnt, r_err_cnt;

  assign w_active   = (r_state != DONE);
  assign w_push_req = w_active && bus.ExpValid && (bus.ExpAddr != ADDR_W'(REG_ZERO));
  assign w_pop_req  = w_active && bus.ActValid && (bus.ActAddr != ADDR_W'(REG_ZERO));

  scb_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .Clock   (Clock),
    .nReset  (nReset),
    .i_push  (w_push_req),
    .i_data  ({bus.ExpAddr, bus.ExpData}),
    .i_pop   (w_rm),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  ({w_head.addr, w_head.data})
  );
  assign w_head.age = r_age;

  // A pushed entry never satisfies a same-cycle pop on an empty queue.
  assign w_cmp    = w_pop_req && !w_empty;
  assign w_unexp  = w_pop_req && w_empty;
  assign w_equal  = (w_head.addr == bus.ActAddr) && (w_head.data == bus.ActData);
  assign w_tmo    = w_active && !w_empty && !w_pop_req && (w_head.age == AGE_W'(TIMEOUT - 1));
  assign w_rm     = w_cmp || w_tmo;
  assign w_ovf    = w_push_req && w_full && !w_rm;
  assign w_err_ev = (w_cmp && !w_equal) || w_unexp || w_tmo || w_ovf;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_age       <= '0;
      r_match     <= 1'b0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_error     <= 1'b0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_match    <= w_cmp && w_equal;
      r_mismatch <= (w_cmp && !w_equal) || w_unexp;
      r_timeout  <= w_tmo;
      r_overflow <= r_overflow || w_ovf;
      r_error    <= r_error || w_err_ev;
      if (w_rm || w_empty)   r_age <= '0;
      else if (w_active)     r_age <= r_age + 1'b1;
      if (w_cmp && w_equal && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
      if (w_err_ev && (r_err_cnt != '1))           r_err_cnt   <= r_err_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.Finish)                        w_state_nxt = DONE;
        else if (bus.ExpValid || bus.ActValid) w_state_nxt = RUN;
      end
      RUN:     if (bus.Finish)     w_state_nxt = DRAIN;
      DRAIN:   if (w_level == '0)  w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.Match    = r_match;
  assign bus.Mismatch = r_mismatch;
  assign bus.Timeout  = r_timeout;
  assign bus.Overflow = r_overflow;
  assign bus.Error    = r_error;
  assign bus.Done     = (r_state == DONE);
  assign bus.MatchCnt = r_match_cnt;
  assign bus.ErrCnt   = r_err_cnt;
  assign bus.Level    = w_level;

`ifdef SCB_LAST_ERR_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_exp;
  logic [DATA_W-1:0] r_err_act;

  // An unexpected commit has no head, so only the commit side is recorded.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_err_addr <= '0;
      r_err_exp  <= '0;
      r_err_act  <= '0;
    end else if (w_cmp && !w_equal) begin
      r_err_addr <= w_head.addr;
      r_err_exp  <= w_head.data;
      r_err_act  <= bus.ActData;
    end else if (w_tmo) begin
      r_err_addr <= w_head.addr;
      r_err_exp  <= w_head.data;
      r_err_act  <= '0;
    end else if (w_unexp) begin
      r_err_addr <= bus.ActAddr;
      r_err_exp  <= '0;
      r_err_act  <= bus.ActData;
    end
  end

  assign bus.ErrAddr = r_err_addr;
  assign bus.ErrExp  = r_err_exp;
  assign bus.ErrAct  = r_err_act;
`endif

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: vector table, directed corner
// sequences and randomized traffic against a queue-level reference model.
module tb_reg_write_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = 4;
  localparam int TMO    = 16;
  localparam int TMO_B  = 4;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  reg_write_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LVL_W(LVL_W)) bus ();
  reg_write_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LVL_W(LVL_W)) bus_b ();

  reg_write_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(CNT_W))
    u_dut (.Clock(Clock), .nReset(nReset), .bus(bus));
  reg_write_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TMO_B), .CNT_W(CNT_W))
    u_dut_b (.Clock(Clock), .nReset(nReset), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                       input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic fin);
    bus.ExpValid = ev; bus.ExpAddr = ea; bus.ExpData = ed;
    bus.ActValid = av; bus.ActAddr = aa; bus.ActData = ad;
    bus.Finish   = fin;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    bus_b.ExpValid = 0; bus_b.ExpAddr = 0; bus_b.ExpData = 0;
    bus_b.ActValid = 0; bus_b.ActAddr = 0; bus_b.ActData = 0; bus_b.Finish = 0;
    nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 nReset = 1'b1;
  endtask

  typedef struct {
    logic              ev;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              m, x, e;
    int                lvl, mc, ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic ev, input int ea, input int ed, input logic av, input int aa,
                     input int ad, input logic m, input logic x, input logic e,
                     input int lvl, input int mc, input int ec);
    vec_t v;
    v.ev = ev; v.ea = ADDR_W'(ea); v.ed = DATA_W'(ed);
    v.av = av; v.aa = ADDR_W'(aa); v.ad = DATA_W'(ad);
    v.m = m; v.x = x; v.e = e; v.lvl = lvl; v.mc = mc; v.ec = ec;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                age;
  } ent_t;
  ent_t q[$];
  int   m_mc, m_ec;
  logic m_ovf, m_err;

  task automatic err_event();
    m_err = 1'b1;
    if (m_ec < (1 << CNT_W) - 1) m_ec++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic em, ex, et;
    logic ev, av;
    logic [ADDR_W-1:0] ea, aa;
    logic [DATA_W-1:0] ed, ad;
    ent_t h;

    // ---- reset state ----
    do_reset();
    chk("rst_level",    bus.Level, 0);
    chk("rst_done",     bus.Done, 0);
    chk("rst_error",    bus.Error, 0);
    chk("rst_overflow", bus.Overflow, 0);
    chk("rst_matchcnt", bus.MatchCnt, 0);
    chk("rst_errcnt",   bus.ErrCnt, 0);

    // ---- vector table: ev ea ed av aa ad | match mism err level mcnt ecnt ----
    add(1, 3, 'h11, 0, 0, 0,      0, 0, 0, 1, 0, 0);
    add(1, 4, 'h22, 0, 0, 0,      0, 0, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 1, 3, 'h11,      1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 4, 'h22,      1, 0, 0, 0, 2, 0);
    add(0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 2, 0);
    add(1, 5, 'hAA, 0, 0, 0,      0, 0, 0, 1, 2, 0);
    add(0, 0, 0, 1, 5, 'hAB,      0, 1, 1, 0, 2, 1);
    add(1, 0, 'h66, 1, 0, 'h55,   0, 0, 1, 0, 2, 1);
    add(0, 0, 0, 1, 6, 1,         0, 1, 1, 0, 2, 2);
    add(0, 0, 0, 0, 0, 0,         0, 0, 1, 0, 2, 2);
    foreach (tbl[i]) begin
      drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].av, tbl[i].aa, tbl[i].ad, 0);
      step();
      chk($sformatf("tbl%0d_match", i),    bus.Match,    tbl[i].m);
      chk($sformatf("tbl%0d_mismatch", i), bus.Mismatch, tbl[i].x);
      chk($sformatf("tbl%0d_error", i),    bus.Error,    tbl[i].e);
      chk($sformatf("tbl%0d_level", i),    bus.Level,    tbl[i].lvl);
      chk($sformatf("tbl%0d_matchcnt", i), bus.MatchCnt, tbl[i].mc);
      chk($sformatf("tbl%0d_errcnt", i),   bus.ErrCnt,   tbl[i].ec);
`ifdef SCB_LAST_ERR_EN
      if (i == 11) begin
        chk("last_err_addr", bus.ErrAddr, 5);
        chk("last_err_exp",  bus.ErrExp,  'hAA);
        chk("last_err_act",  bus.ErrAct,  'hAB);
      end
`endif
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- overflow, then push+pop while full ----
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      drive(1, ADDR_W'(k), DATA_W'(k * 16), 0, 0, 0, 0);
      step();
      if (k == 8) chk("ovf_not_before_ninth", bus.Overflow, 0);
    end
    chk("ovf_level",    bus.Level, 8);
    chk("ovf_sticky",   bus.Overflow, 1);
    chk("ovf_errcnt",   bus.ErrCnt, 1);
    drive(1, 10, 'hA0, 1, 1, 'h10, 0);
    step();
    chk("full_pushpop_match",  bus.Match, 1);
    chk("full_pushpop_level",  bus.Level, 8);
    chk("full_pushpop_errcnt", bus.ErrCnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- finish, drain, done ----
    do_reset();
    drive(1, 2, 'h20, 0, 0, 0, 0); step();
    drive(1, 3, 'h30, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1);    step();
    drive(0, 0, 0, 1, 2, 'h20, 0); step();
    chk("drain_done_low", bus.Done, 0);
    drive(0, 0, 0, 1, 3, 'h30, 0); step();
    chk("drain_level0", bus.Level, 0);
    chk("drain_done_still_low", bus.Done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!bus.Done && n < 10) begin step(); n++; end
    chk("done_latency", n, 1);
    chk("done_matchcnt", bus.MatchCnt, 2);
    drive(1, 9, 'h99, 0, 0, 0, 0); step();
    chk("done_ignores_push", bus.Level, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- reset mid-drain, then Finish straight from IDLE ----
    do_reset();
    drive(1, 2, 'h20, 0, 0, 0, 0); step();
    drive(1, 3, 'h30, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1);    step();
    drive(0, 0, 0, 1, 2, 'h21, 0); step();
    chk("pre_rst_errcnt", bus.ErrCnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 nReset = 1'b0;
    #1;
    chk("midrst_level",    bus.Level, 0);
    chk("midrst_error",    bus.Error, 0);
    chk("midrst_errcnt",   bus.ErrCnt, 0);
    chk("midrst_mismatch", bus.Mismatch, 0);
    chk("midrst_done",     bus.Done, 0);
    @(posedge Clock); #1 nReset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("idle_finish_done", bus.Done, 1);
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- timeout on the TIMEOUT=4 instance ----
    do_reset();
    bus_b.ExpValid = 1; bus_b.ExpAddr = 7; bus_b.ExpData = 1;
    step();
    bus_b.ExpValid = 0; bus_b.ExpAddr = 0; bus_b.ExpData = 0;
    chk("tmo_level_push", bus_b.Level, 1);
    n = 0;
    while (!bus_b.Timeout && n < 10) begin step(); n++; end
    chk("tmo_latency", n, TMO_B);
    chk("tmo_level",   bus_b.Level, 0);
    chk("tmo_errcnt",  bus_b.ErrCnt, 1);
    chk("tmo_error",   bus_b.Error, 1);
`ifdef SCB_LAST_ERR_EN
    chk("tmo_err_addr", bus_b.ErrAddr, 7);
    chk("tmo_err_exp",  bus_b.ErrExp, 1);
    chk("tmo_err_act",  bus_b.ErrAct, 0);
`endif
    step();
    chk("tmo_pulse_one_cycle", bus_b.Timeout, 0);

    // ---- randomized traffic against the queue model ----
    do_reset();
    q.delete();
    m_mc = 0; m_ec = 0; m_ovf = 0; m_err = 0;
    for (int i = 0; i < 800; i++) begin
      int pp, pa;
      case (i / 200)
        0:       begin pp = 50; pa = 50; end
        1:       begin pp = 80; pa = 20; end
        2:       begin pp = 40; pa = 0;  end
        default: begin pp = 20; pa = 70; end
      endcase
      ev = ($urandom_range(0, 99) < pp);
      ea = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
      ed = $urandom;
      av = ($urandom_range(0, 99) < pa);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        aa = q[0].a; ad = q[0].d;
        if ($urandom_range(0, 7) == 0) ad = ad ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
      end else begin
        aa = ADDR_W'($urandom_range(0, 7)); ad = $urandom;
      end

      em = 0; ex = 0; et = 0;
      if (av && aa != 0) begin
        if (q.size() == 0) begin
          ex = 1; err_event();
        end else begin
          h = q.pop_front();
          if (h.a == aa && h.d == ad) begin
            em = 1;
            if (m_mc < (1 << CNT_W) - 1) m_mc++;
          end else begin
            ex = 1; err_event();
          end
        end
      end else if (q.size() > 0) begin
        q[0].age = q[0].age + 1;
        if (q[0].age == TMO) begin
          h = q.pop_front();
          et = 1; err_event();
        end
      end
      if (ev && ea != 0) begin
        if (q.size() < DEPTH) begin
          h.a = ea; h.d = ed; h.age = 0;
          q.push_back(h);
        end else begin
          m_ovf = 1; err_event();
        end
      end

      drive(ev, ea, ed, av, aa, ad, 0);
      step();
      chk($sformatf("rnd%0d_match", i),    bus.Match,    em);
      chk($sformatf("rnd%0d_mismatch", i), bus.Mismatch, ex);
      chk($sformatf("rnd%0d_timeout", i),  bus.Timeout,  et);
      chk($sformatf("rnd%0d_overflow", i), bus.Overflow, m_ovf);
      chk($sformatf("rnd%0d_error", i),    bus.Error,    m_err);
      chk($sformatf("rnd%0d_matchcnt", i), bus.MatchCnt, m_mc);
      chk($sformatf("rnd%0d_errcnt", i),   bus.ErrCnt,   m_ec);
      chk($sformatf("rnd%0d_level", i),    bus.Level,    q.size());
      chk($sformatf("rnd%0d_done", i),     bus.Done,     0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
